// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, reset PC,
// PC step and the opcode values the control unit decodes.
package instr_fetch_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int unsigned PC_STEP          = 4;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I_LOGIC = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_U       = 7'b0110111;

    function automatic logic is_known_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I_LOGIC) || (op == OP_I_LOAD) ||
               (op == OP_S) || (op == OP_B) || (op == OP_U);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Fetch PC register: redirect target (word aligned) takes priority over the
// sequential +4 step, which wraps modulo 2^XLEN.
module fetch_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
        end else if (i_advance) begin
            r_pc <= r_pc + XLEN'(PC_STEP);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests words from instruction
// memory, holds each one for the decoder, and kills fetches on redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      op_o,
    output logic [31:0]     fetch_count_o
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc_o;
    logic [31:0]     r_count;
    logic [XLEN-1:0] w_pc;
    logic            w_capture;
    logic            w_deliver;

    // A word is kept only if it arrives in WAIT and no redirect kills it.
    assign w_capture = (r_state == ST_WAIT) && imem_rsp_valid_i && !redirect_i;
    assign w_deliver = (r_state == ST_HOLD) && instr_ready_i && !redirect_i;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .i_redirect    (redirect_i),
        .i_redirect_pc (redirect_pc_i),
        .i_advance     (w_capture),
        .o_pc          (w_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
            r_pc_o  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_instr <= imem_rdata_i;
                r_pc_o  <= w_pc;
            end
            if (w_deliver) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // NOTE: the default assignment first keeps every path driven, so no latch
    // is inferred when a case arm leaves the state unchanged.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready_i) begin
                    w_state_next = redirect_i ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    w_state_next = imem_rsp_valid_i ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid_i) begin
                    w_state_next = ST_HOLD;
                end
            end
            // The stale response must still be absorbed, even alongside a redirect,
            // otherwise the unit would wait forever for a second one.
            ST_DRAIN: begin
                if (imem_rsp_valid_i) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign imem_req_valid_o = (r_state == ST_REQ);
    assign instr_valid_o    = (r_state == ST_HOLD);
    assign imem_addr_o      = w_pc;
    assign instr_o          = r_instr;
    assign pc_o             = r_pc_o;
    assign op_o             = r_instr[6:0];
    assign fetch_count_o    = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: fetch, stall, backpressure,
// redirect in WAIT and HOLD, PC wrap and asynchronous reset mid-fetch.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [6:0]  op_o;
    logic [31:0] fetch_count_o;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0040_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rdata_i     (imem_rdata_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .op_o             (op_o),
        .fetch_count_o    (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid_o), 32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid_o), 32'd0);
        check({tag, "_addr"}, imem_addr_o, 32'h0040_0000);
        check({tag, "_instr"}, instr_o, 32'd0);
        check({tag, "_pc_o"}, pc_o, 32'd0);
        check({tag, "_count"}, fetch_count_o, 32'd0);
    endtask

    initial begin
        reset            = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rdata_i     = '0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        instr_ready_i    = 1'b0;

        tick();
        tick();
        check_reset_values("rst");

        // First fetch: request in cycle 1, 1-cycle response, valid in cycle 3.
        @(negedge clk);
        reset            = 1'b1;
        imem_req_ready_i = 1'b1;
        tick();
        check("c1_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("c1_addr", imem_addr_o, 32'h0040_0000);
        tick();
        check("c2_req_valid_wait", 32'(imem_req_valid_o), 32'd0);
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rdata_i     = 32'h0050_0093;
        tick();
        imem_rsp_valid_i = 1'b0;
        imem_rdata_i     = 32'hFFFF_FFFF;
        check("c3_instr_valid", 32'(instr_valid_o), 32'd1);
        check("c3_instr", instr_o, 32'h0050_0093);
        check("c3_op", 32'(op_o), 32'(OP_I_LOGIC));
        check("c3_op_known", 32'(is_known_op(op_o)), 32'd1);
        check("c3_pc_o", pc_o, 32'h0040_0000);
        check("c3_next_addr", imem_addr_o, 32'h0040_0004);

        // Consumer stalls for 5 cycles in HOLD.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_instr", instr_o, 32'h0050_0093);
            check("stall_pc_o", pc_o, 32'h0040_0000);
            check("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
            check("stall_count", fetch_count_o, 32'd0);
        end
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check("accept_count", fetch_count_o, 32'd1);
        check("accept_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("accept_instr_valid", 32'(instr_valid_o), 32'd0);

        // Memory backpressure: request held for 3 cycles, accepted on the 4th.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_req_valid", 32'(imem_req_valid_o), 32'd1);
            check("bp_addr", imem_addr_o, 32'h0040_0004);
        end
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        check("bp_wait", 32'(imem_req_valid_o), 32'd0);

        // Redirect in WAIT without a response: drain the stale word.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0103;
        tick();
        redirect_i = 1'b0;
        check("drain_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("drain_addr", imem_addr_o, 32'h0040_0100);
        imem_rsp_valid_i = 1'b1;
        imem_rdata_i     = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("drain_req_again", 32'(imem_req_valid_o), 32'd1);
        check("drain_addr_next", imem_addr_o, 32'h0040_0100);
        check("drain_instr_kept", instr_o, 32'h0050_0093);
        check("drain_no_valid", 32'(instr_valid_o), 32'd0);

        // Fetch a load from the redirect target.
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rdata_i     = 32'h0000_2083;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("ld_op", 32'(op_o), 32'(OP_I_LOAD));
        check("ld_pc_o", pc_o, 32'h0040_0100);
        check("ld_valid", 32'(instr_valid_o), 32'd1);

        // Redirect in HOLD with consumer ready: instruction killed, not counted.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0200;
        instr_ready_i = 1'b1;
        tick();
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        check("kill_count", fetch_count_o, 32'd1);
        check("kill_valid", 32'(instr_valid_o), 32'd0);
        check("kill_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("kill_addr", imem_addr_o, 32'h0040_0200);

        // Redirect in REQ without handshake, misaligned target, then PC wrap.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        check("wrap_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("wrap_addr_aligned", imem_addr_o, 32'hFFFF_FFFC);
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rdata_i     = 32'h0000_00B7;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("wrap_op", 32'(op_o), 32'(OP_U));
        check("wrap_pc_o", pc_o, 32'hFFFF_FFFC);
        check("wrap_next_addr", imem_addr_o, 32'h0000_0000);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check("wrap_count", fetch_count_o, 32'd2);
        check("wrap_req_addr", imem_addr_o, 32'h0000_0000);

        // Asynchronous reset while in WAIT, then a stray response after release.
        imem_req_ready_i = 1'b1;
        tick();
        imem_req_ready_i = 1'b0;
        check("pre_rst_wait", 32'(imem_req_valid_o), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        reset            = 1'b1;
        imem_rsp_valid_i = 1'b1;
        imem_rdata_i     = 32'h1234_5678;
        tick();
        imem_rsp_valid_i = 1'b0;
        check("post_rst_req_valid", 32'(imem_req_valid_o), 32'd1);
        check("post_rst_addr", imem_addr_o, 32'h0040_0000);
        check("post_rst_instr", instr_o, 32'd0);
        tick();
        check("post_rst_no_valid", 32'(instr_valid_o), 32'd0);
        check("post_rst_still_req", 32'(imem_req_valid_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Produces the instruction stream whose opcode field feeds the control unit, i.e. the other end of the OP_i interface.
- Holds the PC and issues one outstanding request at a time to instruction memory over a valid/ready request and valid-only response channel.
- Captures the returned word and presents it downstream with a valid/ready handshake, plus the opcode slice for the decoder.
- Supports branch/jump redirect with kill of in-flight or held fetches.

Parameters:
- XLEN, 32: data/address width.
- RESET_PC, 32'h0040_0000: first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request this cycle.
- imem_addr_o  out  XLEN  fetch address; equals pc register.
- imem_rsp_valid_i  in  1  response word valid (one cycle pulse per accepted request).
- imem_rdata_i  in  32  response instruction word.
- redirect_i  in  1  take new PC (branch/jump resolved).
- redirect_pc_i  in  XLEN  redirect target.
- instr_valid_o  out  1  instr_o/pc_o hold a live instruction.
- instr_ready_i  in  1  consumer accepts instruction.
- instr_o  out  32  held instruction word.
- pc_o  out  XLEN  address of instr_o.
- op_o  out  7  instr_o[6:0], wired to control OP_i.
- fetch_count_o  out  32  delivered-instruction counter.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, pc=RESET_PC, instr_o=0, pc_o=0, fetch_count_o=0.
  - imem_req_valid_o=0, instr_valid_o=0.
- States: IDLE, REQ, WAIT, DRAIN, HOLD.
  - imem_req_valid_o = (state==REQ).
  - instr_valid_o = (state==HOLD).
  - imem_addr_o = pc.
- IDLE: unconditionally -> REQ next cycle. First request is visible in cycle 1 after reset release.
- REQ:
  - req_valid & ready & !redirect -> WAIT.
  - !ready -> stay. The address may change while unaccepted, but only via redirect.
- WAIT: on rsp_valid, capture instr_o=rdata, pc_o=pc, pc=pc+4, -> HOLD.
  - Minimum fetch-to-valid latency is 2 cycles: accept in cycle N, response in N+1, instr_valid_o high in N+2.
- HOLD:
  - instr_o/pc_o stable until accepted.
  - instr_valid & instr_ready & !redirect: fetch_count_o += 1 (wraps 2^32-1 -> 0), -> REQ. One bubble per instruction is accepted by design.
- Redirect (highest priority in every state): pc <= {redirect_pc_i[XLEN-1:2], 2'b00}, then by state:
  - IDLE: -> REQ with new pc.
  - REQ, no handshake: stay REQ; address switches next cycle.
  - REQ with handshake the same cycle: the old-address request is in flight -> DRAIN.
  - WAIT without rsp_valid: -> DRAIN.
  - WAIT with rsp_valid the same cycle: discard the word, -> REQ.
  - DRAIN: update pc, stay DRAIN.
  - HOLD: held instruction killed, instr_ready_i ignored, fetch_count_o not incremented, -> REQ.
- DRAIN: on rsp_valid, discard the word (instr_o/pc_o unchanged), -> REQ. No request is issued while draining.
- Arithmetic: pc+4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- Protocol errors:
  - rsp_valid in IDLE/REQ/HOLD is ignored.
  - At most one request is outstanding at any time.
- Reset mid-operation: immediate return to reset values. Any late response after reset release is ignored, because the FSM is not in WAIT/DRAIN until after a new accept.

Decomposition:
- Shared package holds:
  - fetch state enum encoding (IDLE=0, REQ=1, WAIT=2, DRAIN=3, HOLD=4, 3 bits);
  - RESET_PC default;
  - the opcode localparams (R, I-logic, I-load, S, B, U) shared with the control unit;
  - PC_STEP=4.
- One natural sub-module: fetch_pc_reg (pc register with redirect mux, alignment and +4 increment). The FSM, instruction register and counter stay in the top.

Test Plan:
- Reset release, ready=1, 1-cycle response of 32'h00500093 -> addr 32'h00400000 in cycle 1; instr_valid in cycle 3 with op_o=7'b0010011, pc_o=32'h00400000; next addr 32'h00400004.
- instr_ready=0 for 5 cycles in HOLD -> instr_o/pc_o stable, no new request, fetch_count_o unchanged; then ready=1 for one cycle -> fetch_count_o=1, req_valid next cycle.
- imem_req_ready_i low 3 cycles -> req_valid stays high with constant addr; accept on 4th cycle -> WAIT.
- redirect_i=1, redirect_pc_i=32'h00400103 during WAIT (no response yet) -> DRAIN; response word discarded; next request addr=32'h00400100.
- Redirect while HOLD with instr_ready=1 the same cycle -> instruction killed, fetch_count_o unchanged, next addr = target.
- pc=32'hFFFFFFFC fetched and accepted -> next addr 32'h00000000; reset asserted while in WAIT -> all outputs to reset values asynchronously, stray rsp_valid after release ignored.
